// File: rtl/load_pkg.sv
// Shared types for the load path: access selectors, FSM states and access-size decode.
package load_pkg;

    typedef enum logic [2:0] {
        LB   = 3'd0,
        LH   = 3'd1,
        LW   = 3'd2,
        LBU  = 3'd3,
        LHU  = 3'd4,
        LWU  = 3'd5,
        LD   = 3'd6,
        RSVD = 3'd7
    } load_sel_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD_LO = 3'd1,
        ST_RD_HI = 3'd2,
        ST_CAPT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    function automatic logic [3:0] size_bytes(input logic [2:0] sel);
        logic [3:0] s;
        case (sel)
            LB, LBU: s = 4'd1;
            LH, LHU: s = 4'd2;
            LW, LWU: s = 4'd4;
            LD:      s = 4'd8;
            default: s = 4'd1;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte extraction from a two-word window plus sign/zero extension.
module load_extend
    import load_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0]              word_hi,
    input  logic [XLEN-1:0]              word_lo,
    input  logic [$clog2(XLEN/8)-1:0]    off,
    input  logic [2:0]                   sel,
    output logic [XLEN-1:0]              result
);
    localparam int VW = $clog2(2 * XLEN);

    logic [2*XLEN-1:0] vec_s;
    logic [6:0]        nbits_s;
    logic [VW-1:0]     msb_s;
    logic [XLEN-1:0]   mask_s;
    logic              sign_s;

    // Shift the addressed bytes down, keep S*8 bits, fill the rest with sign or zero
    always_comb begin
        vec_s   = {word_hi, word_lo} >> {off, 3'b000};
        nbits_s = {size_bytes(sel), 3'b000};
        msb_s   = VW'(nbits_s - 7'd1);
        if ((sel == LB) || (sel == LH) || (sel == LW)) begin
            sign_s = vec_s[msb_s];
        end else begin
            sign_s = 1'b0;
        end
        for (int i = 0; i < XLEN; i++) begin
            mask_s[i] = (i < int'(nbits_s));
        end
        result = (vec_s[XLEN-1:0] & mask_s) | (sign_s ? ~mask_s : {XLEN{1'b0}});
    end

endmodule

// File: rtl/load_aligner.sv
// Load path unit: issues one or two aligned reads per request, then returns the
// extracted, extended value through a valid/ready response.
module load_aligner
    import load_pkg::*;
#(
    parameter int XLEN           = 64,
    parameter int ADDR_W         = 64,
    parameter int ALLOW_MISALIGN = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_sel,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err
);
    localparam int BYTES = XLEN / 8;
    localparam int OFF_W = $clog2(BYTES);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        sel_q, sel_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic              split_q, split_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   data_q, data_d;
    logic              err_q, err_d;

    logic [OFF_W-1:0]  req_off_s;
    logic [4:0]        req_span_s;
    logic              req_split_s;
    logic              req_err_s;
    logic [XLEN-1:0]   ext_hi_s, ext_lo_s, ext_res_s;

    // Request classification: word-crossing and error conditions
    always_comb begin
        req_off_s   = req_addr[OFF_W-1:0];
        req_span_s  = 5'(req_off_s) + 5'(size_bytes(req_sel));
        req_split_s = (req_span_s > 5'(BYTES));
        req_err_s   = (req_sel == RSVD) || ((req_sel == LD) && (XLEN == 32)) ||
                      (req_split_s && (ALLOW_MISALIGN == 0));
    end

    // Unsplit accesses see the single word in the low half of the window
    always_comb begin
        if (split_q) begin
            ext_hi_s = mem_rdata;
            ext_lo_s = lo_q;
        end else begin
            ext_hi_s = {XLEN{1'b0}};
            ext_lo_s = mem_rdata;
        end
    end

    load_extend #(.XLEN(XLEN)) u_extend (
        .word_hi (ext_hi_s),
        .word_lo (ext_lo_s),
        .off     (off_q),
        .sel     (sel_q),
        .result  (ext_res_s)
    );

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        sel_d   = sel_q;
        off_d   = off_q;
        split_d = split_q;
        lo_d    = lo_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    sel_d   = req_sel;
                    off_d   = req_off_s;
                    split_d = req_split_s;
                    data_d  = {XLEN{1'b0}};
                    err_d   = req_err_s;
                    state_d = req_err_s ? ST_RESP : ST_RD_LO;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_LO: state_d = split_q ? ST_RD_HI : ST_CAPT;
            ST_RD_HI: begin
                lo_d    = mem_rdata;
                state_d = ST_CAPT;
            end
            ST_CAPT: begin
                data_d  = ext_res_s;
                err_d   = 1'b0;
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    data_d  = {XLEN{1'b0}};
                    err_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            addr_q  <= {ADDR_W{1'b0}};
            sel_q   <= 3'd0;
            off_q   <= {OFF_W{1'b0}};
            split_q <= 1'b0;
            lo_q    <= {XLEN{1'b0}};
            data_q  <= {XLEN{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            split_q <= split_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    // Outputs decoded from state and registers only
    always_comb begin
        req_ready  = (state_q == ST_IDLE);
        mem_rd_en  = (state_q == ST_RD_LO) || (state_q == ST_RD_HI);
        resp_valid = (state_q == ST_RESP);
        resp_data  = data_q;
        resp_err   = err_q;
        case (state_q)
            ST_RD_LO: mem_addr = addr_q;
            ST_RD_HI: mem_addr = addr_q + ADDR_W'(BYTES);
            default:  mem_addr = {ADDR_W{1'b0}};
        endcase
    end

endmodule

// File: tb/tb_load_aligner.sv
// Scoreboard bench: instance 0 splits unaligned loads, instance 1 flags them as errors.
module tb_load_aligner;

    typedef struct {
        logic [63:0] data;
        logic        err;
        int          lat;
        int          acc;
        int          nrd;
        logic [63:0] rd0;
        logic [63:0] rd1;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid [2];
    logic        req_ready [2];
    logic [63:0] req_addr  [2];
    logic [2:0]  req_sel   [2];
    logic        mem_rd_en [2];
    logic [63:0] mem_addr  [2];
    logic [63:0] mem_rdata [2];
    logic        resp_valid[2];
    logic        resp_ready[2];
    logic [63:0] resp_data [2];
    logic        resp_err  [2];

    logic [63:0] mem [logic [63:0]];
    exp_t        exp_q[2][$];
    logic [63:0] rd_q[2][$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          hold[2];
    bit          rr_force[2];

    load_aligner #(.XLEN(64), .ADDR_W(64), .ALLOW_MISALIGN(1)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_addr(req_addr[0]), .req_sel(req_sel[0]), .mem_rd_en(mem_rd_en[0]),
        .mem_addr(mem_addr[0]), .mem_rdata(mem_rdata[0]), .resp_valid(resp_valid[0]),
        .resp_ready(resp_ready[0]), .resp_data(resp_data[0]), .resp_err(resp_err[0]));

    load_aligner #(.XLEN(64), .ADDR_W(64), .ALLOW_MISALIGN(0)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_addr(req_addr[1]), .req_sel(req_sel[1]), .mem_rd_en(mem_rd_en[1]),
        .mem_addr(mem_addr[1]), .mem_rdata(mem_rdata[1]), .resp_valid(resp_valid[1]),
        .resp_ready(resp_ready[1]), .resp_data(resp_data[1]), .resp_err(resp_err[1]));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] mem_read(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        return (a ^ 64'h0000_0005_DEEC_E66D) * 64'h9E37_79B9_7F4A_7C15;
    endfunction

    // Synchronous memory: data one cycle after the strobe, junk otherwise
    always @(posedge clk) begin
        mem_rdata[0] <= mem_rd_en[0] ? mem_read(mem_addr[0]) : 64'hA5A5_5A5A_A5A5_5A5A;
        mem_rdata[1] <= mem_rd_en[1] ? mem_read(mem_addr[1]) : 64'hA5A5_5A5A_A5A5_5A5A;
    end

    task automatic chk(input string name, input logic [63:0] a_v, input logic [63:0] e_v);
        total++;
        if (a_v !== e_v) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, a_v, e_v, $time);
        end
    endtask

    function automatic exp_t mk(input logic [63:0] d, input logic er, input int lat,
                                input int nrd, input logic [63:0] r0, input logic [63:0] r1);
        exp_t e;
        e.data = d; e.err = er; e.lat = lat; e.acc = 0; e.nrd = nrd; e.rd0 = r0; e.rd1 = r1;
        return e;
    endfunction

    // Byte-by-byte reference: gather S bytes starting at a, then extend arithmetically
    function automatic exp_t model(input logic [63:0] a, input logic [2:0] sel, input bit allow);
        int          s;
        bit          split;
        logic [63:0] v, ba, w, base;
        case (sel)
            3'd0, 3'd3: s = 1;
            3'd1, 3'd4: s = 2;
            3'd2, 3'd5: s = 4;
            default:    s = 8;
        endcase
        split = (int'(a[2:0]) + s) > 8;
        base  = {a[63:3], 3'b000};
        if (sel == 3'd7 || (split && !allow)) return mk(64'd0, 1'b1, 1, 0, 64'd0, 64'd0);
        v = 64'd0;
        for (int k = 0; k < s; k++) begin
            ba = a + 64'(k);
            w  = mem_read({ba[63:3], 3'b000});
            v  = v | (((w >> (8 * ba[2:0])) & 64'hFF) << (8 * k));
        end
        if (sel <= 3'd2 && v[8*s-1]) v = v | ~((64'd1 << (8 * s)) - 64'd1);
        return mk(v, 1'b0, split ? 4 : 3, split ? 2 : 1, base, base + 64'd8);
    endfunction

    task automatic issue(input int d, input logic [63:0] a, input logic [2:0] s, input exp_t e);
        int n = 0;
        @(negedge clk);
        while (!req_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[d]) begin
            total++; bad++;
            $display("FAIL req_ready_timeout dut%0d: got 0 expected 1", d);
            return;
        end
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_sel[d]   = s;
        @(posedge clk);
        #1;
        e.acc = cyc;
        exp_q[d].push_back(e);
        if (e.nrd > 0) rd_q[d].push_back(e.rd0);
        if (e.nrd > 1) rd_q[d].push_back(e.rd1);
        // keep a junk request asserted while busy; it must be ignored
        req_addr[d] = {$urandom, $urandom};
        req_sel[d]  = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    task automatic rand_issue(input int d, input bit allow);
        logic [63:0] a;
        logic [2:0]  s;
        a = {52'd0, 12'($urandom)};
        if ($urandom_range(0, 4) == 0) a = {$urandom, $urandom};
        s = 3'($urandom_range(0, 7));
        issue(d, a, s, model(a, s, allow));
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q[0].size() + exp_q[1].size() + rd_q[0].size() + rd_q[1].size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if ((exp_q[0].size() + exp_q[1].size() + rd_q[0].size() + rd_q[1].size()) != 0) begin
            total++; bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q[0].size() + exp_q[1].size());
        end
    endtask

    task automatic chk_reset(input int d);
        chk("rst_req_ready",  64'(req_ready[d]),  64'd1);
        chk("rst_mem_rd_en",  64'(mem_rd_en[d]),  64'd0);
        chk("rst_mem_addr",   mem_addr[d],        64'd0);
        chk("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
        chk("rst_resp_data",  resp_data[d],       64'd0);
        chk("rst_resp_err",   64'(resp_err[d]),   64'd0);
    endtask

    // Consumer back-pressure: random unless a test forces a level
    initial begin
        forever begin
            @(posedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                resp_ready[d] = hold[d] ? rr_force[d] : ($urandom_range(0, 3) != 0);
            end
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_mon
        bit          act;
        int          first;
        logic [63:0] hd;
        logic        he;
        // Monitor: checks read addresses and pops the scoreboard on each response handshake
        initial begin
            exp_t e;
            act = 1'b0;
            forever begin
                @(negedge clk);
                if (mem_rd_en[g]) begin
                    if (rd_q[g].size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_read dut%0d: got addr %h expected no read", g, mem_addr[g]);
                    end else begin
                        chk($sformatf("rd_addr_dut%0d", g), mem_addr[g], rd_q[g].pop_front());
                    end
                end
                if (resp_valid[g]) begin
                    if (exp_q[g].size() == 0) begin
                        total++; bad++;
                        $display("FAIL unexpected_resp dut%0d: got resp_valid=1 expected 0", g);
                    end else begin
                        if (!act) begin
                            act = 1'b1; first = cyc; hd = resp_data[g]; he = resp_err[g];
                        end else begin
                            chk($sformatf("hold_data_dut%0d", g), resp_data[g], hd);
                            chk($sformatf("hold_err_dut%0d", g), 64'(resp_err[g]), 64'(he));
                        end
                        if (resp_ready[g]) begin
                            e = exp_q[g].pop_front();
                            chk($sformatf("data_dut%0d", g), resp_data[g], e.data);
                            chk($sformatf("err_dut%0d", g), 64'(resp_err[g]), 64'(e.err));
                            chk($sformatf("latency_dut%0d", g), 64'(first - e.acc + 1), 64'(e.lat));
                            act = 1'b0;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0; req_addr[d] = 64'd0; req_sel[d] = 3'd0;
            resp_ready[d] = 1'b1; hold[d] = 1'b0; rr_force[d] = 1'b1;
        end
        mem[64'h1000] = 64'h0000_0000_8000_0000;
        mem[64'h2000] = 64'hBEEF_0000_0000_0000;
        mem[64'h3008] = 64'hDEAD_0000_0000_0000;
        mem[64'h3010] = 64'h0000_0000_0000_8001;
        repeat (3) @(negedge clk);
        chk_reset(0);
        chk_reset(1);
        reset_n = 1'b1;

        issue(0, 64'h1003, 3'd0, mk(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1, 64'h1000, 64'd0));
        issue(0, 64'h2006, 3'd4, mk(64'h0000_0000_0000_BEEF, 1'b0, 3, 1, 64'h2000, 64'd0));
        issue(0, 64'h300E, 3'd2, mk(64'hFFFF_FFFF_8001_DEAD, 1'b0, 4, 2, 64'h3008, 64'h3010));
        issue(0, 64'h4000, 3'd7, mk(64'd0, 1'b1, 1, 0, 64'd0, 64'd0));
        issue(1, 64'h4004, 3'd6, mk(64'd0, 1'b1, 1, 0, 64'd0, 64'd0));
        issue(1, 64'h4000, 3'd7, mk(64'd0, 1'b1, 1, 0, 64'd0, 64'd0));
        issue(1, 64'h3008, 3'd6, model(64'h3008, 3'd6, 1'b0));
        issue(0, 64'hFFFF_FFFF_FFFF_FFFC, 3'd6, model(64'hFFFF_FFFF_FFFF_FFFC, 3'd6, 1'b1));
        for (int i = 0; i < 40; i++) rand_issue(0, 1'b1);
        for (int i = 0; i < 25; i++) rand_issue(1, 1'b0);
        drain();

        // consumer stall: response held, no new request accepted
        @(posedge clk); #1;
        hold[0] = 1'b1; rr_force[0] = 1'b0;
        issue(0, 64'h1003, 3'd0, mk(64'hFFFF_FFFF_FFFF_FF80, 1'b0, 3, 1, 64'h1000, 64'd0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[0] && n < 20);
        chk("stall_resp_seen", 64'(resp_valid[0]), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_resp_valid", 64'(resp_valid[0]), 64'd1);
            chk("stall_req_ready", 64'(req_ready[0]), 64'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rr_force[0] = 1'b1;
        @(negedge clk);
        chk("handshake_req_ready", 64'(req_ready[0]), 64'd0);
        @(negedge clk);
        chk("post_handshake_req_ready", 64'(req_ready[0]), 64'd1);
        drain();

        // reset in the middle of a split access
        issue(0, 64'h300E, 3'd2, model(64'h300E, 3'd2, 1'b1));
        chk("rd_hi_strobe", 64'(mem_rd_en[0]), 64'd1);
        chk("rd_hi_addr", mem_addr[0], 64'h3010);
        reset_n = 1'b0;
        #1;
        chk_reset(0);
        void'(exp_q[0].pop_back());
        void'(rd_q[0].pop_back());
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("no_resp_after_reset", 64'(resp_valid[0]), 64'd0);
        end
        hold[0] = 1'b0;
        issue(0, 64'h300E, 3'd2, mk(64'hFFFF_FFFF_8001_DEAD, 1'b0, 4, 2, 64'h3008, 64'h3010));
        for (int i = 0; i < 8; i++) rand_issue(0, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
